fir_mac_sched: RTL and testbench

Time-multiplexed MAC scheduler for the FIR low-pass path. On each rising edge of the `f_s` sample clock, it captures one signed sample into a circular delay line. It then sequences TAPS coefficient reads and multiply-accumulates through a single multiplier, rounds and saturates the sum, and presents one filtered output with a valid strobe. It sits between the function-generator mux output (`din`) and the downstream consumer, and owns the coefficient ROM read port.

---
 rtl/fir_mac_sched_pkg.sv | 51 +++++
 rtl/fir_sched_sync.sv | 23 ++
 rtl/fir_mac_sched.sv | 180 ++++++++++++++++++
 tb/tb_fir_mac_sched.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_mac_sched_pkg.sv
// Shared FSM type and width/constant helpers for fir_mac_sched.
// Build option FIR_MAC_SCHED_SYM_EN selects the symmetric (half-ROM, pre-adder) datapath.
package fir_mac_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPT,
    MAC,
    FLUSH,
    ROUND
  } state_t;

  // Width of the multiplier's sample operand (one extra bit for the pre-adder).
  function automatic int sample_width(input int dw);
`ifdef FIR_MAC_SCHED_SYM_EN
    return dw + 1;
`else
    return dw;
`endif
  endfunction

  function automatic int prod_width(input int dw, input int cw);
    return sample_width(dw) + cw;
  endfunction

  // AW guard bits cover the sum of up to TAPS products without overflow.
  function automatic int acc_width(input int dw, input int cw, input int aw);
    return prod_width(dw, cw) + aw;
  endfunction

  function automatic int mac_steps(input int taps);
`ifdef FIR_MAC_SCHED_SYM_EN
    return taps / 2;
`else
    return taps;
`endif
  endfunction

  function automatic int rnd_const(input int cw);
    return 1 << (cw - 2);
  endfunction

  function automatic int sat_hi(input int dw);
    return (1 << (dw - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int dw);
    return -(1 << (dw - 1));
  endfunction

endpackage

// File: rtl/fir_sched_sync.sv
// Two-flop synchronizer for the asynchronous sample clock plus a rising-edge
// detector; stb is high for exactly one clk cycle per f_s rise.
module fir_sched_sync (
  input  logic clk,
  input  logic rst,
  input  logic f_s,
  output logic stb
);

  logic [2:0] sync_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[1:0], f_s};
    end
  end

  // sync_reg[0] may be metastable; only the second stage and its delayed copy feed logic.
  assign stb = sync_reg[1] & ~sync_reg[2];

endmodule

// File: rtl/fir_mac_sched.sv
// Time-multiplexed FIR MAC scheduler: one multiplier, circular delay line,
// round/saturate output. Define FIR_MAC_SCHED_SYM_EN for the symmetric-filter build.
module fir_mac_sched
  import fir_mac_sched_pkg::*;
#(
  parameter int TAPS = 32,
  parameter int DW   = 12,
  parameter int CW   = 16,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_s,
  input  logic [DW-1:0] din,
  output logic [AW-1:0] coef_addr,
  input  logic [CW-1:0] coef_data,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          busy,
  output logic          overrun
);

  localparam int SW  = sample_width(DW);
  localparam int PW  = prod_width(DW, CW);
  localparam int ACW = acc_width(DW, CW, AW);
  localparam int RW  = ACW + 1;

  localparam logic [AW-1:0]        K_LAST = AW'(mac_steps(TAPS) - 1);
  localparam logic signed [RW-1:0] RND    = RW'(rnd_const(CW));
  localparam logic signed [RW-1:0] SAT_HI = RW'(sat_hi(DW));
  localparam logic signed [RW-1:0] SAT_LO = RW'(sat_lo(DW));

  logic stb;

  fir_sched_sync u_sync (
    .clk (clk),
    .rst (rst),
    .f_s (f_s),
    .stb (stb)
  );

  state_t                 state_reg;
  logic [AW-1:0]          wr_ptr_reg;
  logic [AW-1:0]          rd_lo_reg;
  logic [AW-1:0]          k_reg;
  logic signed [SW-1:0]   x_reg;
  logic                   pv_reg;
  logic signed [ACW-1:0]  acc_reg;
  logic signed [DW-1:0]   dout_reg;
  logic                   dout_valid_reg;
  logic                   busy_reg;
  logic                   overrun_reg;

  logic signed [DW-1:0]   dly [TAPS];
  logic signed [SW-1:0]   tap_sample;
  logic signed [PW-1:0]   prod;
  logic signed [RW-1:0]   rnd_sum;
  logic signed [RW-1:0]   rnd_shift;
  logic signed [DW-1:0]   sat_val;

  // Delay line kept in flops so it can be cleared by reset.
  for (genvar gi = 0; gi < TAPS; gi++) begin : g_dly
    logic signed [DW-1:0] cell_reg;

    always_ff @(posedge clk) begin
      if (!rst) begin
        cell_reg <= '0;
      end else if (state_reg == CAPT && wr_ptr_reg == AW'(gi)) begin
        cell_reg <= $signed(din);
      end
    end

    assign dly[gi] = cell_reg;
  end

`ifdef FIR_MAC_SCHED_SYM_EN
  // Second read pointer walks the mirrored half: x[n-TAPS+1+k] sits at wr_ptr+1+k.
  logic [AW-1:0] rd_hi_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_hi_reg <= '0;
    end else if (state_reg == CAPT) begin
      rd_hi_reg <= wr_ptr_reg + AW'(1);
    end else if (state_reg == MAC) begin
      rd_hi_reg <= rd_hi_reg + AW'(1);
    end
  end

  assign tap_sample = SW'(dly[rd_lo_reg]) + SW'(dly[rd_hi_reg]);
`else
  assign tap_sample = dly[rd_lo_reg];
`endif

  // x_reg and coef_data both refer to the tap addressed in the previous cycle.
  assign prod = PW'(x_reg) * PW'($signed(coef_data));

  always_comb begin
    rnd_sum   = RW'(acc_reg) + RND;
    rnd_shift = rnd_sum >>> (CW - 1);
    sat_val   = rnd_shift[DW-1:0];
    if (rnd_shift > SAT_HI) begin
      sat_val = SAT_HI[DW-1:0];
    end else if (rnd_shift < SAT_LO) begin
      sat_val = SAT_LO[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      rd_lo_reg      <= '0;
      k_reg          <= '0;
      x_reg          <= '0;
      pv_reg         <= 1'b0;
      acc_reg        <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      dout_valid_reg <= 1'b0;
      if (stb && state_reg != IDLE) begin
        overrun_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (stb) begin
            busy_reg  <= 1'b1;
            state_reg <= CAPT;
          end
        end
        CAPT: begin
          acc_reg   <= '0;
          k_reg     <= '0;
          pv_reg    <= 1'b0;
          rd_lo_reg <= wr_ptr_reg;
          state_reg <= MAC;
        end
        MAC: begin
          x_reg     <= tap_sample;
          pv_reg    <= 1'b1;
          rd_lo_reg <= rd_lo_reg - AW'(1);
          if (pv_reg) begin
            acc_reg <= acc_reg + ACW'(prod);
          end
          if (k_reg == K_LAST) begin
            k_reg     <= '0;
            state_reg <= FLUSH;
          end else begin
            k_reg <= k_reg + AW'(1);
          end
        end
        FLUSH: begin
          acc_reg   <= acc_reg + ACW'(prod);
          pv_reg    <= 1'b0;
          state_reg <= ROUND;
        end
        ROUND: begin
          dout_reg       <= sat_val;
          dout_valid_reg <= 1'b1;
          wr_ptr_reg     <= wr_ptr_reg + AW'(1);
          busy_reg       <= 1'b0;
          state_reg      <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign coef_addr  = k_reg;
  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign busy       = busy_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_fir_mac_sched.sv
// Scoreboard bench for fir_mac_sched: a reference FIR model predicts each output
// and its arrival cycle when a sample is driven; the monitor pops and compares.
module tb_fir_mac_sched;
  import fir_mac_sched_pkg::*;

  localparam int TAPS = 32;
  localparam int DW   = 12;
  localparam int CW   = 16;
  localparam int AW   = 5;
  localparam int NMAC = mac_steps(TAPS);
  // stb is sampled by the FSM on the 3rd clk edge after an f_s rise driven at a negedge.
  localparam int SYNC_EDGES = 3;
  localparam int LAT        = NMAC + 3;
  localparam int MIN_PERIOD = NMAC + 4;
  localparam int OVR_PERIOD = MIN_PERIOD / 2 + 2;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          f_s = 1'b0;
  logic [DW-1:0] din = '0;
  logic [AW-1:0] coef_addr;
  logic [CW-1:0] coef_data = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          busy;
  logic          overrun;

  logic [CW-1:0] rom [TAPS];
  int            mdl [TAPS];
  int            mwp     = 0;
  int            next_ok = 0;
  bit            m_ovr   = 1'b0;
  exp_t          sb [$];
  exp_t          e;
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc   = 0;
  int            n_out = 0;

  fir_mac_sched #(
    .TAPS (TAPS),
    .DW   (DW),
    .CW   (CW),
    .AW   (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .f_s        (f_s),
    .din        (din),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Coefficient ROM with one-cycle registered read.
  always @(posedge clk) coef_data <= rom[coef_addr];

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic int model_out();
    longint acc = 0;
    for (int k = 0; k < NMAC; k++) begin
`ifdef FIR_MAC_SCHED_SYM_EN
      acc += longint'($signed(rom[k])) *
             longint'(mdl[(mwp - k) & (TAPS - 1)] + mdl[(mwp + 1 + k) & (TAPS - 1)]);
`else
      acc += longint'($signed(rom[k])) * longint'(mdl[(mwp - k) & (TAPS - 1)]);
`endif
    end
    acc = (acc + (longint'(1) << (CW - 2))) >>> (CW - 1);
    if (acc > longint'((1 << (DW - 1)) - 1)) return (1 << (DW - 1)) - 1;
    if (acc < -longint'(1 << (DW - 1))) return -(1 << (DW - 1));
    return int'(acc);
  endfunction

  task automatic set_rom(input int mode);
    for (int k = 0; k < TAPS; k++) begin
      case (mode)
        0:       rom[k] = CW'(16'h0400);
        1:       rom[k] = CW'(k * 256);
        default: rom[k] = CW'(16'h7FFF);
      endcase
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < TAPS; k++) mdl[k] = 0;
    mwp     = 0;
    next_ok = 0;
    m_ovr   = 1'b0;
    sb.delete();
  endtask

  // Hold reset for ncyc edges, then confirm every output is back at zero.
  task automatic do_reset(input int ncyc);
    @(negedge clk);
    rst = 1'b0;
    f_s = 1'b0;
    clear_model();
    repeat (ncyc) @(posedge clk);
    #2;
    check("rst_dout", $signed(dout), 0);
    check("rst_valid", dout_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_coef_addr", coef_addr, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic sample(input int d, input int period);
    int s;
    @(negedge clk);
    din = DW'(d);
    f_s = 1'b1;
    s   = cyc + SYNC_EDGES;
    if (s >= next_ok) begin
      mdl[mwp] = d;
      sb.push_back('{val: model_out(), cyc: s + LAT});
      mwp      = (mwp + 1) % TAPS;
      next_ok  = s + MIN_PERIOD;
    end else begin
      m_ovr = 1'b1;
    end
    repeat (4) @(negedge clk);
    f_s = 1'b0;
    repeat (period - 5) @(negedge clk);
  endtask

  task automatic drain();
    repeat (LAT + 10) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("busy_idle", busy, 0);
  endtask

  // Output monitor: every dout_valid must match the oldest prediction.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (dout_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("dout", $signed(dout), e.val);
        check("latency", cyc, e.cyc);
        $display("out %0d: dout=%0d exp=%0d cycle=%0d", n_out, $signed(dout), e.val, cyc);
        n_out++;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int s;
    set_rom(0);
    do_reset(3);

    // DC response
    for (int i = 0; i < 34; i++) sample(1000, 100);
    drain();

    // Impulse response
    set_rom(1);
    do_reset(2);
    sample(1024, 40);
    for (int i = 0; i < 33; i++) sample(0, 40);
    drain();

    // Saturation at both rails
    set_rom(2);
    do_reset(2);
    for (int i = 0; i < 34; i++) sample(2047, 40);
    for (int i = 0; i < 34; i++) sample(-2048, 40);
    drain();

    // Overrun: samples arriving faster than one computation
    set_rom(0);
    do_reset(2);
    sample(1000, OVR_PERIOD);
    check("ovr_first", overrun, m_ovr);
    sample(1000, OVR_PERIOD);
    check("ovr_second", overrun, m_ovr);
    for (int i = 0; i < 6; i++) sample(1000, OVR_PERIOD);
    drain();
    repeat (50) @(negedge clk);
    check("ovr_sticky", overrun, m_ovr);

    // Reset in the middle of MAC
    do_reset(2);
    for (int i = 0; i < 34; i++) sample(1000, 40);
    @(negedge clk);
    din = DW'(1000);
    f_s = 1'b1;
    s   = cyc + SYNC_EDGES;
    repeat (4) @(negedge clk);
    f_s = 1'b0;
    while (cyc < s + 7) @(negedge clk);
    check("mid_busy", busy, 1);
    check("mid_coef_addr", coef_addr, 6);
    do_reset(1);
    sample(1000, 40);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
